// File: rtl/time_entry_pkg.sv
// Shared types and constants for the keypad time-entry controller.
package time_entry_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENTRY  = 2'd1,
        ST_COMMIT = 2'd2
    } entry_state_t;

    localparam bcd_t KEY_CLEAR       = 4'hA;
    localparam bcd_t MS_HR_MAX       = 4'd2;
    localparam bcd_t LS_HR_MAX_AT_20 = 4'd3;
    localparam bcd_t MS_MIN_MAX      = 4'd5;
    localparam bcd_t DIGIT_MAX       = 4'd9;

endpackage

// File: rtl/time_entry_ctrl_if.sv
// Keypad/button inputs and clock/alarm load outputs of the time-entry controller.
interface time_entry_ctrl_if;
    import time_entry_pkg::*;

    logic       one_second;
    logic       key_valid;
    bcd_t       key;
    logic       load_time;
    logic       load_alarm;
    bcd_t       new_current_time_ms_hr;
    bcd_t       new_current_time_ls_hr;
    bcd_t       new_current_time_ms_min;
    bcd_t       new_current_time_ls_min;
    logic       load_new_c;
    logic       load_new_a;
    logic       entry_active;
    logic [2:0] digit_count;
    logic       key_err;
    logic       entry_timeout;

    // master drives keys and buttons; slave is the controller itself
    modport master (
        output one_second, key_valid, key, load_time, load_alarm,
        input  new_current_time_ms_hr, new_current_time_ls_hr,
               new_current_time_ms_min, new_current_time_ls_min,
               load_new_c, load_new_a, entry_active, digit_count,
               key_err, entry_timeout
    );

    modport slave (
        input  one_second, key_valid, key, load_time, load_alarm,
        output new_current_time_ms_hr, new_current_time_ls_hr,
               new_current_time_ms_min, new_current_time_ls_min,
               load_new_c, load_new_a, entry_active, digit_count,
               key_err, entry_timeout
    );

endinterface

// File: rtl/entry_digit_validator.sv
// Range check for a digit key at a given HH:MM position (pos 4 and up never accept).
module entry_digit_validator
    import time_entry_pkg::*;
(
    input  logic [2:0] i_pos,
    input  bcd_t       i_key,
    input  bcd_t       i_ms_hr,
    output logic       o_digit_ok
);

    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        o_digit_ok = 1'b0;
        case (i_pos)
            3'd0: o_digit_ok = (i_key <= MS_HR_MAX);
            3'd1: o_digit_ok = (i_ms_hr == MS_HR_MAX) ? (i_key <= LS_HR_MAX_AT_20)
                                                      : (i_key <= DIGIT_MAX);
            3'd2: o_digit_ok = (i_key <= MS_MIN_MAX);
            3'd3: o_digit_ok = (i_key <= DIGIT_MAX);
            default: o_digit_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/time_entry_ctrl.sv
// Keypad time-entry controller: collects HH:MM digits, validates them, and
// commits them to the time counter or alarm register with a one-cycle strobe.
module time_entry_ctrl
    import time_entry_pkg::*;
#(
    parameter int unsigned TIMEOUT_S = 10
) (
    input  logic               clk,
    input  logic               reset,
    time_entry_ctrl_if.slave   bus
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_S - 1);

    entry_state_t r_state;
    logic [2:0]   r_count;
    bcd_t         r_ms_hr, r_ls_hr, r_ms_min, r_ls_min;
    logic         r_load_c, r_load_a, r_key_err, r_timeout;
    logic [7:0]   r_idle_cnt;

    logic w_digit_ok;
    logic w_load_any;
    logic w_is_clear;

    assign w_load_any = bus.load_time | bus.load_alarm;
    assign w_is_clear = (bus.key == KEY_CLEAR);

    entry_digit_validator u_validator (
        .i_pos      (r_count),
        .i_key      (bus.key),
        .i_ms_hr    (r_ms_hr),
        .o_digit_ok (w_digit_ok)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_ms_hr    <= '0;
            r_ls_hr    <= '0;
            r_ms_min   <= '0;
            r_ls_min   <= '0;
            r_load_c   <= 1'b0;
            r_load_a   <= 1'b0;
            r_key_err  <= 1'b0;
            r_timeout  <= 1'b0;
            r_idle_cnt <= '0;
        end else begin
            // NOTE: non-blocking everywhere here; later assignments in the
            // same cycle override earlier defaults without ordering races.
            r_load_c  <= 1'b0;
            r_load_a  <= 1'b0;
            r_key_err <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_idle_cnt <= '0;
                    if (w_load_any) begin
                        r_key_err <= 1'b1;
                    end else if (bus.key_valid && !w_is_clear) begin
                        if (w_digit_ok) begin
                            r_state  <= ST_ENTRY;
                            r_count  <= 3'd1;
                            r_ms_hr  <= bus.key;
                            r_ls_hr  <= '0;
                            r_ms_min <= '0;
                            r_ls_min <= '0;
                        end else begin
                            r_key_err <= 1'b1;
                        end
                    end
                end

                ST_ENTRY: begin
                    // Idle timer first; a commit or key below overrides its effects.
                    if (bus.key_valid || (w_load_any && r_count == 3'd4)) begin
                        r_idle_cnt <= '0;
                    end else if (bus.one_second) begin
                        if (r_idle_cnt == TIMEOUT_LAST) begin
                            r_timeout  <= 1'b1;
                            r_state    <= ST_IDLE;
                            r_count    <= '0;
                            r_ms_hr    <= '0;
                            r_ls_hr    <= '0;
                            r_ms_min   <= '0;
                            r_ls_min   <= '0;
                            r_idle_cnt <= '0;
                        end else begin
                            r_idle_cnt <= r_idle_cnt + 8'd1;
                        end
                    end

                    if (w_load_any) begin
                        if (r_count == 3'd4) begin
                            r_state  <= ST_COMMIT;
                            r_load_c <= bus.load_time;
                            r_load_a <= ~bus.load_time;
                            r_count  <= '0;
                        end else begin
                            r_key_err <= 1'b1;
                        end
                    end else if (bus.key_valid) begin
                        if (w_is_clear) begin
                            r_count  <= '0;
                            r_ms_hr  <= '0;
                            r_ls_hr  <= '0;
                            r_ms_min <= '0;
                            r_ls_min <= '0;
                        end else if (w_digit_ok) begin
                            r_count <= r_count + 3'd1;
                            case (r_count)
                                3'd0:    r_ms_hr  <= bus.key;
                                3'd1:    r_ls_hr  <= bus.key;
                                3'd2:    r_ms_min <= bus.key;
                                3'd3:    r_ls_min <= bus.key;
                                default: ;
                            endcase
                        end else begin
                            r_key_err <= 1'b1;
                        end
                    end
                end

                ST_COMMIT: begin
                    r_state    <= ST_IDLE;
                    r_idle_cnt <= '0;
                end

                default: begin
                    r_state    <= ST_IDLE;
                    r_idle_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.new_current_time_ms_hr  = r_ms_hr;
    assign bus.new_current_time_ls_hr  = r_ls_hr;
    assign bus.new_current_time_ms_min = r_ms_min;
    assign bus.new_current_time_ls_min = r_ls_min;
    assign bus.load_new_c              = r_load_c;
    assign bus.load_new_a              = r_load_a;
    assign bus.entry_active            = (r_state == ST_ENTRY);
    assign bus.digit_count             = r_count;
    assign bus.key_err                 = r_key_err;
    assign bus.entry_timeout           = r_timeout;

endmodule

// File: doc/time_entry_ctrl.md
Name: time_entry_ctrl

Overview:
Keypad time-entry controller; the writer side of the clock/alarm load interface.
- Collects four BCD digits in order HH then MM and validates each digit as it arrives.
- On a load button, drives new_* digits with a one-cycle load_new_c (current time) or load_new_a (alarm time) strobe for the time counter and alarm register.
- Abandons a partial entry after TIMEOUT_S idle seconds.

Parameters:
TIMEOUT_S, 10, number of one_second pulses with no key activity before an in-progress entry is aborted (1..255)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high; clears all state and outputs
one_second  input  1  one-cycle tick, once per second
key_valid  input  1  one-cycle strobe, key is valid
key  input  4  key code: 0-9 digit, 4'hA clear, 4'hB-4'hF illegal
load_time  input  1  one-cycle button strobe: commit entry as current time
load_alarm  input  1  one-cycle button strobe: commit entry as alarm time
new_current_time_ms_hr  output  4  entered hour tens digit
new_current_time_ls_hr  output  4  entered hour units digit
new_current_time_ms_min  output  4  entered minute tens digit
new_current_time_ls_min  output  4  entered minute units digit
load_new_c  output  1  one-cycle commit strobe to the time counter
load_new_a  output  1  one-cycle commit strobe to the alarm register
entry_active  output  1  high while in ENTRY state
digit_count  output  3  digits accepted so far (0..4)
key_err  output  1  one-cycle pulse on rejected key or illegal load
entry_timeout  output  1  one-cycle pulse when the idle timeout aborts an entry

Behaviour:
- Reset: all four digits 0; digit_count 0; all strobes 0; state IDLE; timeout counter 0.
- All outputs are registered. A response appears in cycle N+1 for an input in cycle N.
- States:
  - IDLE: an accepted digit key enters ENTRY with digit_count=1.
  - ENTRY: collects up to four digits.
  - COMMIT: lasts one cycle; the selected strobe is high; then IDLE.
- On entering ENTRY from IDLE, the three unwritten digits are cleared to 0.
- Digit positions and legal ranges:
  - pos0 ms_hr: 0..2.
  - pos1 ls_hr: 0..9, or 0..3 if ms_hr==2.
  - pos2 ms_min: 0..5.
  - pos3 ls_min: 0..9.
- Accepted digit: written to the position given by digit_count; digit_count increments.
- Out-of-range digit: digit and count unchanged; key_err pulses.
- Digit key when digit_count==4: ignored; key_err pulses.
- Illegal key (4'hB-4'hF): key_err pulses; no other effect.
- Clear key (4'hA):
  - In ENTRY: digits to 0, digit_count 0, state stays ENTRY, timeout counter restarts.
  - In IDLE: no effect and no error.
- load_time or load_alarm when digit_count==4: go to COMMIT. In the next cycle, load_new_c (or load_new_a) is high for exactly 1 cycle.
  - The new_* digits hold the entered value during the strobe and are retained after it.
  - digit_count returns to 0.
- Load with digit_count<4, or in IDLE: key_err pulses; no strobe.
- load_time and load_alarm together: load_time wins; only load_new_c is asserted.
- Load and key_valid in the same cycle: the load is processed; the key is dropped silently.
- Timeout:
  - In ENTRY, each one_second increments the idle counter; any key_valid resets it to 0.
  - key_valid and one_second in the same cycle: the counter resets.
  - When the counter reaches TIMEOUT_S: entry_timeout pulses, digits clear to 0, digit_count 0, state IDLE.
  - The counter is held at 0 outside ENTRY.
- Reset mid-entry or mid-COMMIT: immediate clear; no strobe is emitted.

Decomposition:
- Package time_entry_pkg holds:
  - the state enum (IDLE, ENTRY, COMMIT);
  - key codes KEY_CLEAR=4'hA;
  - digit limits MS_HR_MAX=2, LS_HR_MAX_AT_20=3, MS_MIN_MAX=5, DIGIT_MAX=9.
- Sub-module entry_digit_validator (combinational): inputs position, key, stored ms_hr; output digit_ok.

Test Plan:
- Keys 1,7,4,5 then load_time -> digit_count 1,2,3,4; one cycle of load_new_c with digits 1,7,4,5; load_new_a stays 0; IDLE afterwards.
- Keys 2,4 -> second key rejected with key_err, count stays 1. Then keys 3,5,9 and load_alarm -> load_new_a with digits 2,3,5,9.
- Keys 1,2 then load_time -> key_err, no strobe, count stays 2. Key 4'hA -> count 0, digits 0, entry_active stays 1.
- Key 0, then TIMEOUT_S=10 one_second pulses -> entry_timeout on the 10th, IDLE, count 0. A key at pulse 9 restarts the count and gives no timeout.
- Four valid digits, then load_time and load_alarm together -> only load_new_c. Key 4'hC -> key_err only.
- Reset asserted in ENTRY with count 3 -> all outputs 0 on the same edge; no load strobe ever pulses.
